// File: rtl/vga_pkg.sv
// Shared timing defaults, widths and colour LUT for the VGA raster generator.
// Holds 800x600@60 defaults, total-count helper, counter widths and bar colours.
package vga_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  localparam int H_ACTIVE_D = 800;
  localparam int H_FP_D     = 40;
  localparam int H_SYNC_D   = 128;
  localparam int H_BP_D     = 88;
  localparam int V_ACTIVE_D = 600;
  localparam int V_FP_D     = 1;
  localparam int V_SYNC_D   = 4;
  localparam int V_BP_D     = 23;

  localparam bit HSYNC_POL_D = 1'b1;
  localparam bit VSYNC_POL_D = 1'b1;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int h_total(
    input int act, input int fp,
    input int sync, input int bp
  );
    return axis_total(act, fp, sync, bp);
  endfunction

  function automatic int v_total(
    input int act, input int fp,
    input int sync, input int bp
  );
    return axis_total(act, fp, sync, bp);
  endfunction

  localparam int H_TOTAL_D =
    h_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOTAL_D =
    v_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

  // 3-3-2 RGB: white, yellow, cyan, green,
  // magenta, red, blue, black
  localparam logic [7:0] BAR_LUT [8] = '{
    8'hFF, 8'hFC, 8'h1F, 8'h1C,
    8'hE3, 8'hE0, 8'h03, 8'h00
  };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus next-cycle sync/active flags.
// Ports: clk, rst, inc (advance), cnt (position), wrap, sync_nxt, act_nxt.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W      = 11,
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter bit POL    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync_nxt,
  output logic         act_nxt
);

  localparam int TOTAL =
    axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI =
    W'(ACTIVE + FP + SYNC - 1);

  logic at_last;
  logic in_sync;

  assign at_last = (cnt == LAST);
  assign wrap    = inc && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_last ? '0 : cnt + W'(1);
    end
  end

  assign in_sync  = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);
  assign sync_nxt = in_sync ? POL : ~POL;
  assign act_nxt  = (cnt < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// 800x600@60 raster timing generator: registered syncs, active, x/y, strobes.
// Ports: clk, rst, en -> hsync, vsync, active, pixel_x, pixel_y, line_start,
// frame_start, frame_count; rgb test pattern added by VGA_TIMING_TESTPAT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_D,
  parameter int H_FP      = H_FP_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BP      = H_BP_D,
  parameter int V_ACTIVE  = V_ACTIVE_D,
  parameter int V_FP      = V_FP_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BP      = V_BP_D,
  parameter bit HSYNC_POL = HSYNC_POL_D,
  parameter bit VSYNC_POL = VSYNC_POL_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic [HCNT_W-1:0] pixel_x,
  output logic [VCNT_W-1:0] pixel_y,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        frame_count
`ifdef VGA_TIMING_TESTPAT_EN
  ,
  output logic [7:0]        rgb
`endif
);

  logic [HCNT_W-1:0] h_cnt;
  logic [VCNT_W-1:0] v_cnt;
  logic h_wrap, v_wrap;
  logic h_sync, v_sync;
  logic h_act, v_act;

  vga_axis_counter #(
    .W(HCNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP),
    .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .inc(en),
    .cnt(h_cnt), .wrap(h_wrap),
    .sync_nxt(h_sync), .act_nxt(h_act)
  );

  vga_axis_counter #(
    .W(VCNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP),
    .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .inc(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap),
    .sync_nxt(v_sync), .act_nxt(v_act)
  );

  // Outputs present the position the counters hold now,
  // so they trail the counters by one clock. v_wrap fires
  // on the edge that presents the frame's last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      active      <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (en) begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      active      <= h_act && v_act;
      hsync       <= h_sync;
      vsync       <= v_sync;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

`ifdef VGA_TIMING_TESTPAT_EN
  localparam logic [HCNT_W-1:0] H_LAST =
    HCNT_W'(H_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] V_LAST =
    VCNT_W'(V_ACTIVE - 1);

  logic       border;
  logic [7:0] rgb_nxt;

  always_comb begin
    border  = (h_cnt == '0) || (h_cnt == H_LAST) ||
              (v_cnt == '0) || (v_cnt == V_LAST);
    rgb_nxt = '0;
    if (h_act && v_act) begin
      rgb_nxt = border ? 8'hFF : BAR_LUT[h_cnt[9:7]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb <= '0;
    end else if (en) begin
      rgb <= rgb_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size line checks on one instance,
// frame/enable/wrap/reset checks on a reduced-timing instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b = 1'b0, en_b = 1'b0;
  logic rst_s = 1'b0, en_s = 1'b0;

  logic        b_hs, b_vs, b_act, b_ls, b_fs;
  logic [10:0] b_x;
  logic [9:0]  b_y;
  logic [7:0]  b_fc;
  logic        s_hs, s_vs, s_act, s_ls, s_fs;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic [7:0]  s_fc;
`ifdef VGA_TIMING_TESTPAT_EN
  logic [7:0]  b_rgb, s_rgb;
`endif

  vga_timing_gen u_big (
    .clk(clk), .rst(rst_b), .en(en_b),
    .hsync(b_hs), .vsync(b_vs), .active(b_act),
    .pixel_x(b_x), .pixel_y(b_y),
    .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc)
`ifdef VGA_TIMING_TESTPAT_EN
    , .rgb(b_rgb)
`endif
  );

  // 12 x 8 raster: hsync x=9..10, vsync y=5..6, 96 clk/frame
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_sml (
    .clk(clk), .rst(rst_s), .en(en_s),
    .hsync(s_hs), .vsync(s_vs), .active(s_act),
    .pixel_x(s_x), .pixel_y(s_y),
    .line_start(s_ls), .frame_start(s_fs),
    .frame_count(s_fc)
`ifdef VGA_TIMING_TESTPAT_EN
    , .rgb(s_rgb)
`endif
  );

  int nvec = 0;
  int nbad = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seek_b(input int x, input int y,
                        input int lim);
    int n = 0;
    while (!(b_x == 11'(x) && b_y == 10'(y)) && n < lim) begin
      tick();
      n++;
    end
    check("seek_b", 32'(b_x == 11'(x) && b_y == 10'(y)), 1);
  endtask

  task automatic seek_s(input int x, input int y,
                        input int lim);
    int n = 0;
    while (!(s_x == 11'(x) && s_y == 10'(y)) && n < lim) begin
      tick();
      n++;
    end
    check("seek_s", 32'(s_x == 11'(x) && s_y == 10'(y)), 1);
  endtask

  int n_act, n_hs, hs_x, n_ls, n_fs, fs_per;
  int n_vs, vs_lo, vs_hi, n_bad_act, n;

  initial begin
    #2;
    rst_b = 1'b1;
    rst_s = 1'b1;
    tick();
    tick();
    check("rst_x", b_x, 0);
    check("rst_y", b_y, 0);
    check("rst_act", b_act, 0);
    check("rst_hs", b_hs, 0);
    check("rst_vs", b_vs, 0);
    check("rst_ls", b_ls, 0);
    check("rst_fs", b_fs, 0);
    check("rst_fc", b_fc, 0);
    rst_b = 1'b0;
    rst_s = 1'b0;
    en_b  = 1'b1;
    tick();
    check("b0_x", b_x, 0);
    check("b0_y", b_y, 0);
    check("b0_act", b_act, 1);
    check("b0_ls", b_ls, 1);
    check("b0_fs", b_fs, 1);
    check("b0_hs", b_hs, 0);
    check("s_frozen_act", s_act, 0);
`ifdef VGA_TIMING_TESTPAT_EN
    check("rgb_00", b_rgb, 8'hFF);
`endif

    // one full 1056-clock line
    n_act = 0; n_hs = 0; hs_x = -1; n_ls = 0;
    for (int i = 0; i < 1056; i++) begin
      if (b_act) n_act++;
      if (b_hs) begin
        if (n_hs == 0) hs_x = int'(b_x);
        n_hs++;
      end
      if (b_ls) n_ls++;
      tick();
    end
    check("line_act", n_act, 800);
    check("line_hs_n", n_hs, 128);
    check("line_hs_x", hs_x, 840);
    check("line_ls_n", n_ls, 1);
    check("l1_x", b_x, 0);
    check("l1_y", b_y, 1);
    check("l1_ls", b_ls, 1);
    check("l1_fs", b_fs, 0);
    check("l1_vs", b_vs, 0);

`ifdef VGA_TIMING_TESTPAT_EN
    seek_b(150, 10, 12000);
    check("rgb_150", b_rgb, 8'hFC);
    seek_b(400, 10, 400);
    check("rgb_400", b_rgb, 8'h1C);
    seek_b(799, 10, 500);
    check("rgb_799", b_rgb, 8'hFF);
    seek_b(820, 10, 100);
    check("rgb_820", b_rgb, 8'h00);
    check("act_820", b_act, 0);
`endif
    en_b = 1'b0;

    // two frames on the reduced raster
    en_s = 1'b1;
    tick();
    check("s0_fs", s_fs, 1);
    check("s0_fc", s_fc, 0);
    n_fs = 0; fs_per = -1; n_vs = 0;
    vs_lo = 99; vs_hi = -1; n_act = 0; n_bad_act = 0;
    for (int i = 0; i < 192; i++) begin
      if (s_fs) begin
        if (n_fs == 1) fs_per = i;
        n_fs++;
      end
      if (s_vs) begin
        n_vs++;
        if (int'(s_y) < vs_lo) vs_lo = int'(s_y);
        if (int'(s_y) > vs_hi) vs_hi = int'(s_y);
      end
      if (s_act) n_act++;
      if (s_act && s_y >= 10'd4) n_bad_act++;
      if (i == 94) check("fc_before_last", s_fc, 0);
      if (i == 95) begin
        check("last_x", s_x, 11);
        check("last_y", s_y, 7);
        check("fc_at_last", s_fc, 1);
      end
      tick();
    end
    check("fs_n", n_fs, 2);
    check("fs_per", fs_per, 96);
    check("vs_n", n_vs, 48);
    check("vs_lo", vs_lo, 5);
    check("vs_hi", vs_hi, 6);
    check("s_act_n", n_act, 64);
    check("act_below", n_bad_act, 0);
    check("f2_fs", s_fs, 1);
    check("f2_fc", s_fc, 2);

    // freeze at the last pixel of a frame
    seek_s(11, 7, 200);
    check("pre_hold_fc", s_fc, 3);
    en_s = 1'b0;
    repeat (37) tick();
    check("hold_x", s_x, 11);
    check("hold_y", s_y, 7);
    check("hold_fc", s_fc, 3);
    check("hold_hs", s_hs, 0);
    check("hold_act", s_act, 0);
    en_s = 1'b1;
    tick();
    check("res_x", s_x, 0);
    check("res_y", s_y, 0);
    check("res_fs", s_fs, 1);
    check("res_fc", s_fc, 3);

    // reset in the middle of a frame
    seek_s(5, 3, 200);
    rst_s = 1'b1;
    #1;
    check("mid_rst_x", s_x, 0);
    check("mid_rst_y", s_y, 0);
    check("mid_rst_fc", s_fc, 0);
    check("mid_rst_act", s_act, 0);
    tick();
    rst_s = 1'b0;
    tick();
    check("rel_x", s_x, 0);
    check("rel_fs", s_fs, 1);
    check("rel_fc", s_fc, 0);
    check("rel_hs", s_hs, 0);
    check("rel_vs", s_vs, 0);
    check("rel_act", s_act, 1);

    // frame_count wrap 255 -> 0
    n = 0;
    while (!(s_fc == 8'd255 && s_fs) && n < 260 * 96) begin
      tick();
      n++;
    end
    check("seek_fc255", 32'(s_fc == 8'd255 && s_fs), 1);
    repeat (94) tick();
    check("w_x10", s_x, 10);
    check("w_fc255", s_fc, 255);
    check("w_hs10", s_hs, 1);
    tick();
    check("w_x11", s_x, 11);
    check("w_fc0", s_fc, 0);
    check("w_hs11", s_hs, 0);
    check("w_vs11", s_vs, 0);
    tick();
    check("w_fs", s_fs, 1);
    check("w_act", s_act, 1);
    check("w_fc_next", s_fc, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
